// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/ROR/SRA): one register stage per shift level,
// largest shift first, with valid/ready backpressure, a sideband tag and flush.
module shift_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRA = 2'b11
  } mode_e;

  // Right shifts share one form: the vacated MSBs take 'fill' (zero, the rotated
  // word itself, or the sign captured at entry).
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input mode_e mode,
                                                input logic sign,
                                                input int amt);
    logic [WIDTH-1:0] fill;
    fill = (mode == MODE_ROR) ? d : (mode == MODE_SRA) ? {WIDTH{sign}} : '0;
    if (mode == MODE_SLL) return d << amt;
    return (d >> amt) | (fill << (WIDTH - amt));
  endfunction

  logic             valid_q [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  logic [TAG_W-1:0] tag_q   [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  mode_e            mode_q  [SHW];
  logic             sign_q  [SHW];

  logic             v_in  [SHW];
  logic [WIDTH-1:0] d_in  [SHW];
  logic [TAG_W-1:0] t_in  [SHW];
  logic [SHW-1:0]   s_in  [SHW];
  mode_e            m_in  [SHW];
  logic             sg_in [SHW];

  logic advance;

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT  = 1 << (SHW - 1 - k);
    localparam bit LAST = (k == SHW - 1);

    if (k == 0) begin : g_head
      assign v_in[k]  = in_valid;
      assign d_in[k]  = in_data;
      assign t_in[k]  = in_tag;
      assign s_in[k]  = in_shamt;
      assign m_in[k]  = mode_e'(in_mode);
      assign sg_in[k] = in_data[WIDTH-1];
    end else begin : g_body
      assign v_in[k]  = valid_q[k-1];
      assign d_in[k]  = data_q[k-1];
      assign t_in[k]  = tag_q[k-1];
      assign s_in[k]  = shamt_q[k-1];
      assign m_in[k]  = mode_q[k-1];
      assign sg_in[k] = sign_q[k-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value and the pipe moves one slot per edge.
    always_ff @(posedge clk) begin
      if (reset || flush)  valid_q[k] <= 1'b0;
      else if (advance)    valid_q[k] <= v_in[k];
    end

    // NOTE: payload registers are not reset (only the output stage is zeroed); they
    // load only behind a valid token, so bubbles never carry undefined data forward.
    always_ff @(posedge clk) begin
      if (reset) begin
        if (LAST) begin
          data_q[k] <= '0;
          tag_q[k]  <= '0;
        end
      end else if (advance && v_in[k]) begin
        data_q[k]  <= s_in[k][SHW-1-k] ? shift_by(d_in[k], m_in[k], sg_in[k], AMT)
                                       : d_in[k];
        tag_q[k]   <= t_in[k];
        shamt_q[k] <= s_in[k];
        mode_q[k]  <= m_in[k];
        sign_q[k]  <= sg_in[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: a 32-bit and an 8-bit instance checked every cycle against
// a delay-line model whose results come from plain whole-word shift arithmetic.
module tb_shift_pipe;
  localparam int SLL = 0, SRL = 1, ROR = 2, SRA = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_in_mode;
  logic [4:0]  a_in_shamt, a_in_tag, a_out_tag;
  logic [31:0] a_in_data, a_out_data;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_in_mode;
  logic [2:0]  b_in_shamt;
  logic [1:0]  b_in_tag, b_out_tag;
  logic [7:0]  b_in_data, b_out_data;

  shift_pipe #(.WIDTH(32), .TAG_W(5)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_shamt(a_in_shamt), .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag));

  shift_pipe #(.WIDTH(8), .TAG_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_shamt(b_in_shamt), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag));

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-word reference shift for a w-bit datapath.
  function automatic logic [63:0] ref_op(logic [63:0] d, int s, int m, int w);
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    d    = d & mask;
    case (m)
      SLL:     r = (d << s) & mask;
      SRL:     r = d >> s;
      ROR:     r = ((d >> s) | (d << (w - s))) & mask;
      default: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
    endcase
    return r;
  endfunction

  // Delay-line model: a result computed at acceptance reaches the output slot
  // after 'depth' advancing edges.
  typedef struct {
    bit          v;
    logic [63:0] d;
    logic [63:0] t;
  } slot_t;
  slot_t m_slot [2][8];
  int    depth  [2] = '{5, 3};

  task automatic upd(int u, bit rst, bit fl, bit iv, bit orr,
                     logic [63:0] d, int s, int mode, logic [63:0] tag, int w);
    bit adv;
    adv = orr || !m_slot[u][depth[u]-1].v;
    if (rst || fl) begin
      for (int i = 0; i < depth[u]; i++) m_slot[u][i].v = 1'b0;
    end else if (adv) begin
      for (int i = depth[u] - 1; i > 0; i--) m_slot[u][i] = m_slot[u][i-1];
      m_slot[u][0].v = iv;
      m_slot[u][0].d = ref_op(d, s, mode, w);
      m_slot[u][0].t = tag;
    end
  endtask

  always @(posedge clk) begin
    upd(0, reset, a_flush, a_in_valid, a_out_ready, 64'(a_in_data), int'(a_in_shamt),
        int'(a_in_mode), 64'(a_in_tag), 32);
    upd(1, reset, b_flush, b_in_valid, b_out_ready, 64'(b_in_data), int'(b_in_shamt),
        int'(b_in_mode), 64'(b_in_tag), 8);
  end

  task automatic cmp(int u, bit ov, logic [63:0] od, logic [63:0] ot, bit ir, bit orr);
    slot_t e;
    e = m_slot[u][depth[u]-1];
    check(u == 0 ? "a_out_valid" : "b_out_valid", 64'(ov), 64'(e.v));
    check(u == 0 ? "a_in_ready" : "b_in_ready", 64'(ir), 64'(orr || !e.v));
    if (e.v && ov) begin
      check(u == 0 ? "a_out_data" : "b_out_data", od, e.d);
      check(u == 0 ? "a_out_tag" : "b_out_tag", ot, e.t);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cmp(0, a_out_valid, 64'(a_out_data), 64'(a_out_tag), a_in_ready, a_out_ready);
      cmp(1, b_out_valid, 64'(b_out_data), 64'(b_out_tag), b_in_ready, b_out_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    a_in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Single op on the 32-bit unit with an empty pipe: checks latency and literal result.
  task automatic send_a(string name, int mode, int shamt, logic [31:0] d,
                        logic [4:0] tag, logic [31:0] exp);
    int lat;
    a_in_valid = 1'b1;
    a_in_mode  = 2'(mode);
    a_in_shamt = 5'(shamt);
    a_in_data  = d;
    a_in_tag   = tag;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd5);
    check({name, "_data"}, 64'(a_out_data), 64'(exp));
    check({name, "_tag"}, 64'(a_out_tag), 64'(tag));
    #1;
    idle(2);
  endtask

  task automatic rand_a_op();
    a_in_mode  = 2'($urandom);
    a_in_shamt = 5'($urandom);
    a_in_data  = $urandom;
    a_in_tag   = 5'($urandom);
  endtask

  logic [31:0] hold_d;
  logic [4:0]  hold_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    a_in_mode = '0; a_in_shamt = '0; a_in_data = '0; a_in_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_mode = '0; b_in_shamt = '0; b_in_data = '0; b_in_tag = '0;

    // Pin the reference model to hand-computed values.
    check("pin_sll", ref_op(64'h1, 31, SLL, 32), 64'h8000_0000);
    check("pin_sra", ref_op(64'h8000_0000, 4, SRA, 32), 64'hF800_0000);
    check("pin_srl", ref_op(64'h8000_0000, 4, SRL, 32), 64'h0800_0000);
    check("pin_ror", ref_op(64'h1234_5678, 8, ROR, 32), 64'h7812_3456);
    check("pin_ror0", ref_op(64'h1234_5678, 0, ROR, 32), 64'h1234_5678);
    check("pin_sra8", ref_op(64'h90, 3, SRA, 8), 64'hF2);

    step();
    step();
    reset = 1'b0;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_data", 64'(a_out_data), 64'd0);
    check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_out_data", 64'(b_out_data), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);

    send_a("sll31", SLL, 31, 32'h0000_0001, 5'd3, 32'h8000_0000);
    send_a("sra4", SRA, 4, 32'h8000_0000, 5'd9, 32'hF800_0000);
    send_a("srl4", SRL, 4, 32'h8000_0000, 5'd17, 32'h0800_0000);
    send_a("ror8", ROR, 8, 32'h1234_5678, 5'd30, 32'h7812_3456);
    send_a("sll0", SLL, 0, 32'hA5C3_0F96, 5'd1, 32'hA5C3_0F96);
    send_a("srl0", SRL, 0, 32'hA5C3_0F96, 5'd2, 32'hA5C3_0F96);
    send_a("ror0", ROR, 0, 32'hA5C3_0F96, 5'd4, 32'hA5C3_0F96);
    send_a("sra0", SRA, 0, 32'hA5C3_0F96, 5'd8, 32'hA5C3_0F96);

    // Back-to-back stream, alternating modes, tags 0..7.
    for (int i = 0; i < 8; i++) begin
      rand_a_op();
      a_in_mode  = 2'(i % 4);
      a_in_tag   = 5'(i);
      a_in_valid = 1'b1;
      step();
    end
    idle(8);

    // Backpressure: fill the pipe with the consumer stalled, then hold 3 cycles.
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_a_op();
      a_in_valid = 1'b1;
      step();
    end
    hold_d = a_out_data;
    hold_t = a_out_tag;
    for (int i = 0; i < 3; i++) begin
      rand_a_op();
      step();
      check("bp_in_ready", 64'(a_in_ready), 64'd0);
      check("bp_out_valid", 64'(a_out_valid), 64'd1);
      check("bp_data_stable", 64'(a_out_data), 64'(hold_d));
      check("bp_tag_stable", 64'(a_out_tag), 64'(hold_t));
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    idle(8);

    // Flush with three ops in flight and a fourth being presented.
    for (int i = 0; i < 3; i++) begin
      rand_a_op();
      a_in_valid = 1'b1;
      step();
    end
    rand_a_op();
    a_flush = 1'b1;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("flush_out_valid", 64'(a_out_valid), 64'd0);
      step();
    end
    send_a("post_flush", SRA, 13, 32'hC000_1234, 5'd21, 32'hFFFE_0000);

    // Random traffic with backpressure, occasional flush and one mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      rand_a_op();
      a_in_valid  = ($urandom_range(3) != 0);
      a_out_ready = ($urandom_range(3) != 0);
      a_flush     = ($urandom_range(63) == 0);
      if (i == 1500) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out_valid", 64'(a_out_valid), 64'd0);
        check("midrst_out_data", 64'(a_out_data), 64'd0);
        check("midrst_out_tag", 64'(a_out_tag), 64'd0);
      end else begin
        step();
      end
    end
    a_flush     = 1'b0;
    a_out_ready = 1'b1;
    idle(10);

    // Exhaustive sweep of the 8-bit unit, streamed one op per cycle.
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 8; s++)
        for (int d = 0; d < 256; d++) begin
          b_in_valid = 1'b1;
          b_in_mode  = 2'(m);
          b_in_shamt = 3'(s);
          b_in_data  = 8'(d);
          b_in_tag   = 2'($urandom);
          step();
        end
    b_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
